// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the instruction/data bus arbiter: bus widths, the
// write-disable encoding, state and owner encodings, and the mux select type.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int BYTE_WEN = 4;
    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;
    localparam int AXI_SIZE = 2;

    // All byte enables low means a read
    localparam logic [BYTE_WEN-1:0] WR_DISABLE = '0;

    // Debug owner codes seen on arb_owner
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_I    = 2'b01;
    localparam logic [1:0] OWNER_D    = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_OWN_I = 2'b01,
        ARB_OWN_D = 2'b10
    } arb_state_t;

    // Which master is currently routed to the downstream port
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_I    = 2'b01,
        SEL_D    = 2'b10
    } arb_sel_t;

    // Master that completed the most recent transaction
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    function automatic logic [1:0] owner_code(input arb_state_t s);
        case (s)
            ARB_OWN_I: owner_code = OWNER_I;
            ARB_OWN_D: owner_code = OWNER_D;
            default:   owner_code = OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// bus_arb_mux
// Combinational two-to-one request mux. Routes the selected master's request
// fields and pipeline stall onto the downstream bus; with no selection the
// bus is quiet (bus_en=0, bus_stall=0).
// Ports: sel (owner select), i_* (instruction request), d_* (data request),
//        bus_* (downstream request and forwarded stall).
// -----------------------------------------------------------------------------
module bus_arb_mux
    import bus_arbiter_pkg::*;
(
    input  arb_sel_t              sel,
    input  logic                  i_en,
    input  logic [ADDR_BUS-1:0]   i_addr,
    input  logic [AXI_SIZE-1:0]   i_size,
    input  logic                  i_cached,
    input  logic                  i_stall,
    input  logic                  d_en,
    input  logic [BYTE_WEN-1:0]   d_wen,
    input  logic [ADDR_BUS-1:0]   d_addr,
    input  logic [DATA_BUS-1:0]   d_wdata,
    input  logic [AXI_SIZE-1:0]   d_size,
    input  logic                  d_cached,
    input  logic                  d_stall,
    output logic                  bus_en,
    output logic [BYTE_WEN-1:0]   bus_wen,
    output logic [ADDR_BUS-1:0]   bus_addr,
    output logic [DATA_BUS-1:0]   bus_wdata,
    output logic [AXI_SIZE-1:0]   bus_size,
    output logic                  bus_cached,
    output logic                  bus_stall
);

    // The instruction side never writes, so its write fields are forced quiet
    always_comb begin
        bus_en     = 1'b0;
        bus_wen    = WR_DISABLE;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_size   = '0;
        bus_cached = 1'b0;
        bus_stall  = 1'b0;
        case (sel)
            SEL_I: begin
                bus_en     = i_en;
                bus_addr   = i_addr;
                bus_size   = i_size;
                bus_cached = i_cached;
                bus_stall  = i_stall;
            end
            SEL_D: begin
                bus_en     = d_en;
                bus_wen    = d_wen;
                bus_addr   = d_addr;
                bus_wdata  = d_wdata;
                bus_size   = d_size;
                bus_cached = d_cached;
                bus_stall  = d_stall;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Merges the instruction-fetch and data-access buses onto one downstream
// bus_* port. A master is granted combinationally in IDLE (zero added
// latency) and keeps ownership until its transaction completes or it drops
// its request. Non-owners that are requesting see a stall request.
// Ports: aclk/aresetn (clock, async active-low reset), i_* / d_* master
//        requests and returned stall/read data, bus_* downstream request,
//        bus_rdata/bus_streq from downstream, arb_owner debug (00/01/10).
// Build option: BUS_ARB_RR_EN - simultaneous requests in IDLE alternate
//        against the last completed master; otherwise data has priority.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_en,
    input  logic [ADDR_BUS-1:0]   i_addr,
    input  logic [AXI_SIZE-1:0]   i_size,
    input  logic                  i_cached,
    input  logic                  i_stall,
    output logic [DATA_BUS-1:0]   i_rdata,
    output logic                  i_streq,
    input  logic                  d_en,
    input  logic [BYTE_WEN-1:0]   d_wen,
    input  logic [ADDR_BUS-1:0]   d_addr,
    input  logic [DATA_BUS-1:0]   d_wdata,
    input  logic [AXI_SIZE-1:0]   d_size,
    input  logic                  d_cached,
    input  logic                  d_stall,
    output logic [DATA_BUS-1:0]   d_rdata,
    output logic                  d_streq,
    output logic                  bus_en,
    output logic [BYTE_WEN-1:0]   bus_wen,
    output logic [ADDR_BUS-1:0]   bus_addr,
    output logic [DATA_BUS-1:0]   bus_wdata,
    output logic [AXI_SIZE-1:0]   bus_size,
    output logic                  bus_cached,
    output logic                  bus_stall,
    input  logic [DATA_BUS-1:0]   bus_rdata,
    input  logic                  bus_streq,
    output logic [1:0]            arb_owner
);

    arb_state_t state, state_next;
    arb_gnt_t   last_gnt, last_gnt_next;
    arb_sel_t   sel;

    // State, last completed master and the debug owner code
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ARB_IDLE;
            last_gnt  <= GNT_I;
            arb_owner <= OWNER_NONE;
        end else begin
            state     <= state_next;
            last_gnt  <= last_gnt_next;
            arb_owner <= owner_code(state_next);
        end
    end

    // Transitions look at the routed master through the mux outputs, so the
    // same code serves the IDLE winner and the current owner
    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        case (state)
            ARB_IDLE: begin
                if (sel != SEL_NONE) begin
                    if (bus_streq || bus_stall) begin
                        state_next = (sel == SEL_D) ? ARB_OWN_D : ARB_OWN_I;
                    end else begin
                        last_gnt_next = (sel == SEL_D) ? GNT_D : GNT_I;
                    end
                end
            end
            ARB_OWN_I, ARB_OWN_D: begin
                if (!bus_en) begin
                    state_next = ARB_IDLE;
                end else if (!bus_streq && !bus_stall) begin
                    state_next    = ARB_IDLE;
                    last_gnt_next = (state == ARB_OWN_D) ? GNT_D : GNT_I;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Select and stall requests: an owner always keeps the mux, even after
    // dropping its request, so the other master cannot slip in mid-cycle
    always_comb begin
        sel = SEL_NONE;
        case (state)
            ARB_OWN_I: sel = SEL_I;
            ARB_OWN_D: sel = SEL_D;
            default: begin
                if (d_en && i_en) begin
`ifdef BUS_ARB_RR_EN
                    sel = (last_gnt == GNT_D) ? SEL_I : SEL_D;
`else
                    sel = SEL_D;
`endif
                end else if (d_en) begin
                    sel = SEL_D;
                end else if (i_en) begin
                    sel = SEL_I;
                end
            end
        endcase

        i_streq = 1'b0;
        d_streq = 1'b0;
        if (i_en) begin
            i_streq = (sel == SEL_I) ? bus_streq : 1'b1;
        end
        if (d_en) begin
            d_streq = (sel == SEL_D) ? bus_streq : 1'b1;
        end
    end

    assign i_rdata = bus_rdata;
    assign d_rdata = bus_rdata;

    bus_arb_mux u_mux (
        .sel        (sel),
        .i_en       (i_en),
        .i_addr     (i_addr),
        .i_size     (i_size),
        .i_cached   (i_cached),
        .i_stall    (i_stall),
        .d_en       (d_en),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_size     (d_size),
        .d_cached   (d_cached),
        .d_stall    (d_stall),
        .bus_en     (bus_en),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_size   (bus_size),
        .bus_cached (bus_cached),
        .bus_stall  (bus_stall)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: idle zero-wait read, collision, owner
// stall, withdrawal and asynchronous reset mid-transaction. The collision
// after a data completion expects the instruction master when BUS_ARB_RR_EN
// is defined and the data master otherwise.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        i_en;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        i_cached;
    logic        i_stall;
    logic [31:0] i_rdata;
    logic        i_streq;
    logic        d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_cached;
    logic        d_stall;
    logic [31:0] d_rdata;
    logic        d_streq;
    logic        bus_en;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_cached;
    logic        bus_stall;
    logic [31:0] bus_rdata;
    logic        bus_streq;
    logic [1:0]  arb_owner;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDR0 = 32'hBFC0_0000;
    localparam logic [31:0] I_ADDR1 = 32'h0040_0000;
    localparam logic [31:0] D_ADDR0 = 32'h8000_1000;
    localparam logic [31:0] D_ADDR1 = 32'h8000_2000;

    bus_arbiter dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_en       (i_en),
        .i_addr     (i_addr),
        .i_size     (i_size),
        .i_cached   (i_cached),
        .i_stall    (i_stall),
        .i_rdata    (i_rdata),
        .i_streq    (i_streq),
        .d_en       (d_en),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_size     (d_size),
        .d_cached   (d_cached),
        .d_stall    (d_stall),
        .d_rdata    (d_rdata),
        .d_streq    (d_streq),
        .bus_en     (bus_en),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_size   (bus_size),
        .bus_cached (bus_cached),
        .bus_stall  (bus_stall),
        .bus_rdata  (bus_rdata),
        .bus_streq  (bus_streq),
        .arb_owner  (arb_owner)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Move one cycle on; inputs change 1 ns after the rising edge
    task automatic applyStimulus();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] rr_owner;
        logic [31:0] rr_addr;

        aresetn = 1'b0;
        i_en = 1'b0; i_addr = '0; i_size = 2'd2; i_cached = 1'b1; i_stall = 1'b0;
        d_en = 1'b0; d_wen = '0; d_addr = '0; d_wdata = '0; d_size = 2'd2;
        d_cached = 1'b0; d_stall = 1'b0;
        bus_rdata = 32'h1234_5678; bus_streq = 1'b0;

        #1;
        checkOutput("reset_owner", {30'd0, arb_owner}, 32'h0);
        checkOutput("reset_bus_en", {31'd0, bus_en}, 32'h0);
        checkOutput("reset_bus_stall", {31'd0, bus_stall}, 32'h0);
        checkOutput("reset_i_streq", {31'd0, i_streq}, 32'h0);
        checkOutput("i_rdata", i_rdata, 32'h1234_5678);
        checkOutput("d_rdata", d_rdata, 32'h1234_5678);
        #11 aresetn = 1'b1;

        // Idle single read with zero wait: same-cycle propagation, no state change
        applyStimulus();
        i_en = 1'b1; i_addr = I_ADDR0;
        #1;
        checkOutput("idle_bus_en", {31'd0, bus_en}, 32'h1);
        checkOutput("idle_bus_addr", bus_addr, I_ADDR0);
        checkOutput("idle_bus_wen", {28'd0, bus_wen}, 32'h0);
        checkOutput("idle_bus_cached", {31'd0, bus_cached}, 32'h1);
        checkOutput("idle_i_streq", {31'd0, i_streq}, 32'h0);
        applyStimulus();
        i_en = 1'b0;
        checkOutput("idle_owner", {30'd0, arb_owner}, 32'h0);

        // Collision: data wins and holds the bus for five stalled cycles
        i_en = 1'b1; i_addr = I_ADDR1;
        d_en = 1'b1; d_addr = D_ADDR0; d_wen = 4'hF; d_wdata = 32'hDEAD_BEEF;
        bus_streq = 1'b1;
        #1;
        checkOutput("coll_addr0", bus_addr, D_ADDR0);
        checkOutput("coll_wen", {28'd0, bus_wen}, 32'hF);
        checkOutput("coll_wdata", bus_wdata, 32'hDEAD_BEEF);
        checkOutput("coll_i_streq0", {31'd0, i_streq}, 32'h1);
        checkOutput("coll_d_streq0", {31'd0, d_streq}, 32'h1);
        for (int k = 1; k < 5; k++) begin
            applyStimulus();
            #1;
            checkOutput("coll_owner", {30'd0, arb_owner}, 32'h2);
            checkOutput("coll_addr", bus_addr, D_ADDR0);
            checkOutput("coll_i_streq", {31'd0, i_streq}, 32'h1);
        end
        applyStimulus();
        bus_streq = 1'b0;
        #1;
        checkOutput("coll_done_d_streq", {31'd0, d_streq}, 32'h0);
        checkOutput("coll_done_i_streq", {31'd0, i_streq}, 32'h1);

        // One cycle after completion the instruction request reaches the bus
        applyStimulus();
        d_en = 1'b0; d_wen = '0; bus_streq = 1'b1;
        #1;
        checkOutput("after_d_owner", {30'd0, arb_owner}, 32'h0);
        checkOutput("after_d_addr", bus_addr, I_ADDR1);
        checkOutput("after_d_i_streq", {31'd0, i_streq}, 32'h1);

        // Owner I stalls after its data arrives; D waits for three cycles
        applyStimulus();
        bus_streq = 1'b0; i_stall = 1'b1;
        d_en = 1'b1; d_addr = D_ADDR1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("stall_owner", {30'd0, arb_owner}, 32'h1);
            checkOutput("stall_d_streq", {31'd0, d_streq}, 32'h1);
            checkOutput("stall_bus_stall", {31'd0, bus_stall}, 32'h1);
            checkOutput("stall_addr", bus_addr, I_ADDR1);
            applyStimulus();
        end
        i_stall = 1'b0;
        #1;
        checkOutput("release_owner", {30'd0, arb_owner}, 32'h1);
        checkOutput("release_bus_stall", {31'd0, bus_stall}, 32'h0);
        checkOutput("release_i_streq", {31'd0, i_streq}, 32'h0);

        // Data granted next, then withdraws mid-stall while I is pending
        applyStimulus();
        i_en = 1'b0; bus_streq = 1'b1;
        #1;
        checkOutput("wd_grant_owner", {30'd0, arb_owner}, 32'h0);
        checkOutput("wd_grant_addr", bus_addr, D_ADDR1);
        applyStimulus();
        i_en = 1'b1; i_addr = I_ADDR0;
        #1;
        checkOutput("wd_own_d", {30'd0, arb_owner}, 32'h2);
        checkOutput("wd_pending_i_streq", {31'd0, i_streq}, 32'h1);
        applyStimulus();
        d_en = 1'b0;
        #1;
        checkOutput("wd_bus_en", {31'd0, bus_en}, 32'h0);
        checkOutput("wd_i_streq", {31'd0, i_streq}, 32'h1);
        applyStimulus();
        #1;
        checkOutput("wd_idle_owner", {30'd0, arb_owner}, 32'h0);
        checkOutput("wd_i_addr", bus_addr, I_ADDR0);
        checkOutput("wd_i_bus_en", {31'd0, bus_en}, 32'h1);
        checkOutput("wd_i_sees_streq", {31'd0, i_streq}, 32'h1);
        applyStimulus();
        bus_streq = 1'b0;
        #1;
        checkOutput("wd_own_i", {30'd0, arb_owner}, 32'h1);

        // Zero-wait data access leaves the last completed master as D
        applyStimulus();
        i_en = 1'b0; d_en = 1'b1; d_addr = D_ADDR0;
        #1;
        checkOutput("d_zero_addr", bus_addr, D_ADDR0);
        checkOutput("d_zero_streq", {31'd0, d_streq}, 32'h0);

        // Simultaneous requests right after a D completion
`ifdef BUS_ARB_RR_EN
        rr_owner = 2'b01; rr_addr = I_ADDR0;
`else
        rr_owner = 2'b10; rr_addr = D_ADDR0;
`endif
        applyStimulus();
        i_en = 1'b1; bus_streq = 1'b1;
        #1;
        checkOutput("both_addr", bus_addr, rr_addr);
        applyStimulus();
        #1;
        checkOutput("both_owner", {30'd0, arb_owner}, {30'd0, rr_owner});
        bus_streq = 1'b0;

        // After that completion the next collision goes to D in both builds
        applyStimulus();
        bus_streq = 1'b1;
        #1;
        checkOutput("second_addr", bus_addr, D_ADDR0);
        applyStimulus();
        #1;
        checkOutput("pre_reset_owner", {30'd0, arb_owner}, 32'h2);

        // Asynchronous reset in the middle of a data transaction
        #1 aresetn = 1'b0;
        #1;
        checkOutput("async_owner", {30'd0, arb_owner}, 32'h0);
        checkOutput("async_idle_addr", bus_addr, D_ADDR0);
        #2 aresetn = 1'b1;
        applyStimulus();
        #1;
        checkOutput("fresh_owner", {30'd0, arb_owner}, 32'h2);
        checkOutput("fresh_i_streq", {31'd0, i_streq}, 32'h1);

        i_en = 1'b0; d_en = 1'b0; bus_streq = 1'b0;
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
